exec_datapath: RTL and testbench

//  Execution end of the control-unit command interface: consumes the one-hot command strobes (mem-ref ADD/LOAD/STORE/BRANCH/ISZ,
//  reg-ref CLA/CLE/CMA/LDI/CIR/CIL/INC), owns AC, E, DR and PC, and runs the memory transactions the commands need.
//  It returns a single-cycle o_ex_done per accepted command, which the control unit uses to advance its FSM. Sits between the

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/exec_datapath_if.sv | 52 +++++
 rtl/exec_alu.sv | 47 ++++
 rtl/exec_datapath.sv | 161 ++++++++++++++++
 tb/tb_exec_datapath.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execution datapath: width defaults, FSM state
// encodings, command bit positions and ALU operation codes.
package cpu_pkg;

    localparam int unsigned DEF_DWIDTH = 16;
    localparam int unsigned DEF_AWIDTH = 12;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Bit positions in the packed command vector
    localparam int unsigned NCMD       = 12;
    localparam int unsigned CMD_ADD    = 0;
    localparam int unsigned CMD_LOAD   = 1;
    localparam int unsigned CMD_STORE  = 2;
    localparam int unsigned CMD_BRANCH = 3;
    localparam int unsigned CMD_ISZ    = 4;
    localparam int unsigned CMD_CLA    = 5;
    localparam int unsigned CMD_CLE    = 6;
    localparam int unsigned CMD_CMA    = 7;
    localparam int unsigned CMD_LDI    = 8;
    localparam int unsigned CMD_CIR    = 9;
    localparam int unsigned CMD_CIL    = 10;
    localparam int unsigned CMD_INC    = 11;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_CLA,
        ALU_CLE,
        ALU_CMA,
        ALU_PASS,
        ALU_INC,
        ALU_CIR,
        ALU_CIL,
        ALU_ADD,
        ALU_INCM
    } alu_op_t;

    // True when exactly one command bit is set
    function automatic logic is_one_hot(input logic [NCMD-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NCMD; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/exec_datapath_if.sv
// Command, status and RAM-port signals between control unit, execution
// datapath and RAM. slave = datapath side, master = environment side.
interface exec_datapath_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 12
);
    logic              i_execute;
    logic              i_add;
    logic              i_load;
    logic              i_store;
    logic              i_branch;
    logic              i_isz;
    logic              i_clr_ac;
    logic              i_clr_e;
    logic              i_comp_ac;
    logic              i_load_ac;
    logic              i_cir_r;
    logic              i_cir_l;
    logic              i_inc_ac;
    logic [AWIDTH-1:0] i_addr;
    logic [7:0]        i_imm;
    logic              i_pc_inc;
    logic              i_clr_reg;
    logic              o_mem_ce;
    logic              o_mem_we;
    logic [AWIDTH-1:0] o_mem_addr;
    logic [DWIDTH-1:0] o_mem_wdata;
    logic [DWIDTH-1:0] i_mem_rdata;
    logic              o_ex_done;
    logic              o_err;
    logic              o_busy;
    logic [DWIDTH-1:0] o_ac;
    logic              o_e;
    logic [AWIDTH-1:0] o_pc;

    modport slave (
        input  i_execute, i_add, i_load, i_store, i_branch, i_isz,
               i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac,
               i_addr, i_imm, i_pc_inc, i_clr_reg, i_mem_rdata,
        output o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
               o_ex_done, o_err, o_busy, o_ac, o_e, o_pc
    );

    modport master (
        output i_execute, i_add, i_load, i_store, i_branch, i_isz,
               i_clr_ac, i_clr_e, i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac,
               i_addr, i_imm, i_pc_inc, i_clr_reg, i_mem_rdata,
        input  o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
               o_ex_done, o_err, o_busy, o_ac, o_e, o_pc
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational accumulator ALU shared by register-reference commands and
// the memory-reference result paths (LOAD, ADD, ISZ increment).
module exec_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH
) (
    input  logic [DWIDTH-1:0] ac,
    input  logic              e,
    input  logic [DWIDTH-1:0] operand,
    input  alu_op_t           op,
    output logic [DWIDTH-1:0] ac_nxt,
    output logic              e_nxt,
    output logic              zero
);

    localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);

    logic [DWIDTH:0] sum;

    // Next AC/E for the selected operation; unlisted ops hold both
    always_comb begin
        ac_nxt = ac;
        e_nxt  = e;
        sum    = {1'b0, ac} + {1'b0, operand};
        case (op)
            ALU_CLA:  ac_nxt = '0;
            ALU_CLE:  e_nxt  = 1'b0;
            ALU_CMA:  ac_nxt = ~ac;
            ALU_PASS: ac_nxt = operand;
            ALU_INC:  ac_nxt = ac + ONE;
            ALU_CIR: begin
                ac_nxt = {e, ac[DWIDTH-1:1]};
                e_nxt  = ac[0];
            end
            ALU_CIL: begin
                ac_nxt = {ac[DWIDTH-2:0], e};
                e_nxt  = ac[DWIDTH-1];
            end
            ALU_ADD:  {e_nxt, ac_nxt} = sum;
            ALU_INCM: ac_nxt = operand + ONE;
            default: ;
        endcase
        zero = (ac_nxt == '0);
    end

endmodule

// File: rtl/exec_datapath.sv
// Execution datapath: accepts one-hot commands from the control unit,
// owns AC/E/DR/PC, sequences RAM reads/writes and pulses o_ex_done once
// per accepted command.
module exec_datapath
    import cpu_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
) (
    input logic           clk,
    input logic           reset_n,
    exec_datapath_if.slave bus
);

    logic [2:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic              is_add_q, is_load_q, is_isz_q;
    logic              err_q;
    logic              dr_zero_q;
    logic [DWIDTH-1:0] ac_q, dr_q;
    logic              e_q;
    logic [AWIDTH-1:0] pc_q;

    logic [NCMD-1:0]   cmd_in;
    logic              accept, cmd_ok, reg_ref, mem_rd;
    alu_op_t           alu_op;
    logic [DWIDTH-1:0] alu_opnd, alu_ac;
    logic              alu_e, alu_zero;

    assign cmd_in = {bus.i_inc_ac, bus.i_cir_l, bus.i_cir_r, bus.i_load_ac,
                     bus.i_comp_ac, bus.i_clr_e, bus.i_clr_ac, bus.i_isz,
                     bus.i_branch, bus.i_store, bus.i_load, bus.i_add};

    assign accept  = (state_q == ST_IDLE) && bus.i_execute && !bus.i_clr_reg;
    assign cmd_ok  = is_one_hot(cmd_in);
    assign reg_ref = |cmd_in[CMD_INC:CMD_CLA];
    assign mem_rd  = cmd_in[CMD_ADD] | cmd_in[CMD_LOAD] | cmd_in[CMD_ISZ];

    // ALU op/operand: immediate-side reg-ref ops in IDLE, RAM data in RD_WAIT
    always_comb begin
        alu_op   = ALU_NOP;
        alu_opnd = bus.i_mem_rdata;
        if (state_q == ST_IDLE) begin
            alu_opnd = {{(DWIDTH-8){1'b0}}, bus.i_imm};
            if (cmd_ok) begin
                if      (cmd_in[CMD_CLA]) alu_op = ALU_CLA;
                else if (cmd_in[CMD_CLE]) alu_op = ALU_CLE;
                else if (cmd_in[CMD_CMA]) alu_op = ALU_CMA;
                else if (cmd_in[CMD_LDI]) alu_op = ALU_PASS;
                else if (cmd_in[CMD_CIR]) alu_op = ALU_CIR;
                else if (cmd_in[CMD_CIL]) alu_op = ALU_CIL;
                else if (cmd_in[CMD_INC]) alu_op = ALU_INC;
            end
        end else if (state_q == ST_RD_WAIT) begin
            if      (is_add_q)  alu_op = ALU_ADD;
            else if (is_load_q) alu_op = ALU_PASS;
            else if (is_isz_q)  alu_op = ALU_INCM;
        end
    end

    exec_alu #(.DWIDTH(DWIDTH)) u_alu (
        .ac      (ac_q),
        .e       (e_q),
        .operand (alu_opnd),
        .op      (alu_op),
        .ac_nxt  (alu_ac),
        .e_nxt   (alu_e),
        .zero    (alu_zero)
    );

    // Next-state decode; i_clr_reg aborts to IDLE from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!cmd_ok)                 state_d = ST_DONE;
                    else if (mem_rd)             state_d = ST_RD;
                    else if (cmd_in[CMD_STORE])  state_d = ST_WR;
                    else                         state_d = ST_DONE;
                end
            end
            ST_RD:      state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = is_isz_q ? ST_WR : ST_DONE;
            ST_WR:      state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (bus.i_clr_reg) state_d = ST_IDLE;
    end

    // FSM state and latched command context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            is_add_q  <= 1'b0;
            is_load_q <= 1'b0;
            is_isz_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q    <= bus.i_addr;
                is_add_q  <= cmd_in[CMD_ADD];
                is_load_q <= cmd_in[CMD_LOAD];
                is_isz_q  <= cmd_in[CMD_ISZ];
                err_q     <= !cmd_ok;
            end
        end
    end

    // Architectural registers; PC priority: clear > branch/skip > fetch increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac_q      <= '0;
            e_q       <= 1'b0;
            dr_q      <= '0;
            pc_q      <= '0;
            dr_zero_q <= 1'b0;
        end else if (bus.i_clr_reg) begin
            ac_q      <= '0;
            e_q       <= 1'b0;
            dr_q      <= '0;
            pc_q      <= '0;
            dr_zero_q <= 1'b0;
        end else begin
            if ((accept && cmd_ok && reg_ref) ||
                (state_q == ST_RD_WAIT && (is_add_q || is_load_q))) begin
                ac_q <= alu_ac;
                e_q  <= alu_e;
            end
            if (state_q == ST_RD_WAIT && is_isz_q) begin
                dr_q      <= alu_ac;
                dr_zero_q <= alu_zero;
            end
            if (accept && cmd_ok && cmd_in[CMD_BRANCH])
                pc_q <= bus.i_addr;
            else if (state_q == ST_WR && is_isz_q && dr_zero_q)
                pc_q <= pc_q + AWIDTH'(1);
            else if (bus.i_pc_inc)
                pc_q <= pc_q + AWIDTH'(1);
        end
    end

    // Outputs decoded from state; i_clr_reg masks a pending write or done
    // in the same cycle so the abort takes effect before the clock edge.
    always_comb begin
        bus.o_mem_ce    = ((state_q == ST_RD) || (state_q == ST_WR)) && !bus.i_clr_reg;
        bus.o_mem_we    = (state_q == ST_WR) && !bus.i_clr_reg;
        bus.o_mem_addr  = bus.o_mem_ce ? addr_q : '0;
        bus.o_mem_wdata = bus.o_mem_we ? (is_isz_q ? dr_q : ac_q) : '0;
        bus.o_ex_done   = (state_q == ST_DONE) && !bus.i_clr_reg;
        bus.o_err       = bus.o_ex_done && err_q;
        bus.o_busy      = (state_q != ST_IDLE);
        bus.o_ac        = ac_q;
        bus.o_e         = e_q;
        bus.o_pc        = pc_q;
    end

endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath: command table with hand-computed
// AC/E/PC/latency/error/RAM-cycle expectations plus multi-cycle sequences.
module tb_exec_datapath;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    exec_datapath_if #(.DWIDTH(16), .AWIDTH(12)) bus();

    exec_datapath #(.DWIDTH(16), .AWIDTH(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] C_ADD = 12'h001, C_LOAD = 12'h002, C_STORE = 12'h004,
                            C_BR  = 12'h008, C_ISZ  = 12'h010, C_CLA   = 12'h020,
                            C_CLE = 12'h040, C_CMA  = 12'h080, C_LDI   = 12'h100,
                            C_CIR = 12'h200, C_CIL  = 12'h400, C_INC   = 12'h800;

    // RAM model and preload port
    logic [15:0] mem [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a = '0;
    logic [15:0] pl_d = '0;

    int ce_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int n_cmp = 0, n_bad = 0;

    // Synchronous single-port RAM: read data valid the cycle after ce&!we
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (bus.o_mem_ce) begin
            if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
            else bus.i_mem_rdata <= mem[bus.o_mem_addr];
        end
    end

    // Activity counters
    always @(posedge clk) begin
        if (bus.o_mem_ce) ce_cnt++;
        if (bus.o_mem_ce && bus.o_mem_we) wr_cnt++;
        if (bus.o_ex_done) done_cnt++;
    end

    typedef struct {
        logic [11:0] cmd;
        logic [11:0] addr;
        logic [7:0]  imm;
        logic [15:0] ac;
        logic        e;
        logic [11:0] pc;
        int          lat;
        logic        err;
        int          mc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cmd(input logic [11:0] c);
        bus.i_add = c[0]; bus.i_load = c[1]; bus.i_store = c[2]; bus.i_branch = c[3];
        bus.i_isz = c[4]; bus.i_clr_ac = c[5]; bus.i_clr_e = c[6]; bus.i_comp_ac = c[7];
        bus.i_load_ac = c[8]; bus.i_cir_r = c[9]; bus.i_cir_l = c[10]; bus.i_inc_ac = c[11];
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Drive a command for one accept edge; returns #1 after that edge (cycle T+1)
    task automatic start(input logic [11:0] c, input logic [11:0] a, input logic [7:0] im);
        @(negedge clk);
        set_cmd(c); bus.i_addr = a; bus.i_imm = im; bus.i_execute = 1'b1;
        @(posedge clk); #1;
        bus.i_execute = 1'b0; set_cmd('0);
    endtask

    task automatic issue(input logic [11:0] c, input logic [11:0] a, input logic [7:0] im,
                         output int lat, output logic err);
        start(c, a, im);
        lat = 1;
        while (bus.o_ex_done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        err = bus.o_err;
        if (bus.o_ex_done !== 1'b1) lat = -1;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, c0, w0, d0;
        logic err;

        set_cmd('0);
        bus.i_execute = 1'b0; bus.i_addr = '0; bus.i_imm = '0;
        bus.i_pc_inc = 1'b0; bus.i_clr_reg = 1'b0;

        // Preload RAM while held in reset
        poke(12'h010, 16'h0001);
        poke(12'h030, 16'hFFFF);
        poke(12'h040, 16'h1234);
        poke(12'h050, 16'h8001);
        poke(12'h060, 16'h8000);
        poke(12'h080, 16'hDEAD);

        chk("rst ac",    bus.o_ac, 0);
        chk("rst e",     bus.o_e, 0);
        chk("rst pc",    bus.o_pc, 0);
        chk("rst done",  bus.o_ex_done, 0);
        chk("rst err",   bus.o_err, 0);
        chk("rst busy",  bus.o_busy, 0);
        chk("rst ce",    bus.o_mem_ce, 0);
        chk("rst we",    bus.o_mem_we, 0);
        chk("rst addr",  bus.o_mem_addr, 0);
        chk("rst wdata", bus.o_mem_wdata, 0);

        @(negedge clk); reset_n = 1'b1;

        //            cmd          addr     imm    ac        e     pc       lat err mc
        tbl.push_back('{C_LDI,     12'h000, 8'hA5, 16'h00A5, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_LDI,     12'h000, 8'h00, 16'h0000, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CMA,     12'h000, 8'h00, 16'hFFFF, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_ADD,     12'h010, 8'h00, 16'h0000, 1'b1, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_INC,     12'h000, 8'h00, 16'h0001, 1'b1, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CLE,     12'h000, 8'h00, 16'h0001, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CLA,     12'h000, 8'h00, 16'h0000, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_LOAD,    12'h040, 8'h00, 16'h1234, 1'b0, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_STORE,   12'h020, 8'h00, 16'h1234, 1'b0, 12'h000, 2, 1'b0, 1});
        tbl.push_back('{C_CLA,     12'h000, 8'h00, 16'h0000, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_LOAD,    12'h020, 8'h00, 16'h1234, 1'b0, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_LOAD,    12'h050, 8'h00, 16'h8001, 1'b0, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_CIL,     12'h000, 8'h00, 16'h0002, 1'b1, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CIR,     12'h000, 8'h00, 16'h8001, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CIR,     12'h000, 8'h00, 16'h4000, 1'b1, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_CIL,     12'h000, 8'h00, 16'h8001, 1'b0, 12'h000, 1, 1'b0, 0});
        tbl.push_back('{C_ADD|C_LOAD, 12'h010, 8'h00, 16'h8001, 1'b0, 12'h000, 1, 1'b1, 0});
        tbl.push_back('{12'h000,   12'h000, 8'h00, 16'h8001, 1'b0, 12'h000, 1, 1'b1, 0});
        tbl.push_back('{C_ADD,     12'h060, 8'h00, 16'h0001, 1'b1, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_BR,      12'hFFF, 8'h00, 16'h0001, 1'b1, 12'hFFF, 1, 1'b0, 0});
        tbl.push_back('{C_ISZ,     12'h030, 8'h00, 16'h0001, 1'b1, 12'h000, 4, 1'b0, 2});
        tbl.push_back('{C_ISZ,     12'h010, 8'h00, 16'h0001, 1'b1, 12'h000, 4, 1'b0, 2});
        tbl.push_back('{C_LOAD,    12'h030, 8'h00, 16'h0000, 1'b1, 12'h000, 3, 1'b0, 1});
        tbl.push_back('{C_LOAD,    12'h010, 8'h00, 16'h0002, 1'b1, 12'h000, 3, 1'b0, 1});

        foreach (tbl[i]) begin
            c0 = ce_cnt;
            issue(tbl[i].cmd, tbl[i].addr, tbl[i].imm, lat, err);
            chk($sformatf("v%0d lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d err", i), err, tbl[i].err);
            chk($sformatf("v%0d ac", i),  bus.o_ac, tbl[i].ac);
            chk($sformatf("v%0d e", i),   bus.o_e, tbl[i].e);
            chk($sformatf("v%0d pc", i),  bus.o_pc, tbl[i].pc);
            chk($sformatf("v%0d ramcyc", i), ce_cnt - c0, tbl[i].mc);
        end

        // STORE strobes at T+1, done at T+2 (AC=0002)
        start(C_STORE, 12'h070, 8'h00);
        chk("st ce",    bus.o_mem_ce, 1);
        chk("st we",    bus.o_mem_we, 1);
        chk("st addr",  bus.o_mem_addr, 12'h070);
        chk("st wdata", bus.o_mem_wdata, 16'h0002);
        chk("st done1", bus.o_ex_done, 0);
        @(posedge clk); #1;
        chk("st done2", bus.o_ex_done, 1);
        chk("st ce2",   bus.o_mem_ce, 0);
        @(posedge clk); #1;
        chk("st mem",   mem[12'h070], 16'h0002);

        // ISZ on 0000: read T+1, idle bus T+2, write 0001 at T+3, no skip
        start(C_ISZ, 12'h030, 8'h00);
        chk("isz rd ce",   bus.o_mem_ce, 1);
        chk("isz rd we",   bus.o_mem_we, 0);
        chk("isz rd addr", bus.o_mem_addr, 12'h030);
        @(posedge clk); #1;
        chk("isz wait ce", bus.o_mem_ce, 0);
        chk("isz busy",    bus.o_busy, 1);
        @(posedge clk); #1;
        chk("isz wr we",    bus.o_mem_we, 1);
        chk("isz wr wdata", bus.o_mem_wdata, 16'h0001);
        @(posedge clk); #1;
        chk("isz done", bus.o_ex_done, 1);
        chk("isz pc",   bus.o_pc, 12'h000);
        @(posedge clk); #1;

        // i_clr_reg during ISZ RD_WAIT: no write, no done, registers cleared
        start(C_ISZ, 12'h010, 8'h00);
        @(posedge clk); #1;
        w0 = wr_cnt; d0 = done_cnt;
        bus.i_clr_reg = 1'b1;
        @(posedge clk); #1;
        bus.i_clr_reg = 1'b0;
        chk("clr busy", bus.o_busy, 0);
        chk("clr ac",   bus.o_ac, 0);
        chk("clr e",    bus.o_e, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("clr wr",   wr_cnt - w0, 0);
        chk("clr done", done_cnt - d0, 0);
        chk("clr mem",  mem[12'h010], 16'h0002);

        // PC wrap on fetch increment, then branch beats a simultaneous increment
        issue(C_BR, 12'hFFF, 8'h00, lat, err);
        chk("pcw lat", lat, 1);
        @(negedge clk); bus.i_pc_inc = 1'b1;
        @(posedge clk); #1; bus.i_pc_inc = 1'b0;
        chk("pc wrap", bus.o_pc, 12'h000);
        @(negedge clk); bus.i_pc_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1; bus.i_pc_inc = 1'b0;
        chk("pc inc3", bus.o_pc, 12'h003);
        @(negedge clk);
        bus.i_pc_inc = 1'b1; set_cmd(C_BR); bus.i_addr = 12'h0A0; bus.i_execute = 1'b1;
        @(posedge clk); #1;
        bus.i_pc_inc = 1'b0; set_cmd('0); bus.i_execute = 1'b0;
        chk("pc prio", bus.o_pc, 12'h0A0);
        repeat (2) @(posedge clk);
        #1;

        // execute while busy is ignored (LOAD 070 = 0002 while CMA pulsed)
        d0 = done_cnt;
        start(C_LOAD, 12'h070, 8'h00);
        bus.i_execute = 1'b1; set_cmd(C_CMA);
        @(posedge clk); #1;
        bus.i_execute = 1'b0; set_cmd('0);
        repeat (6) @(posedge clk);
        #1;
        chk("busy done", done_cnt - d0, 1);
        chk("busy ac",   bus.o_ac, 16'h0002);

        // Asynchronous reset while a STORE is in WR: strobes drop at once, no write
        start(C_STORE, 12'h080, 8'h00);
        chk("ar we pre", bus.o_mem_we, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar we",   bus.o_mem_we, 0);
        chk("ar ce",   bus.o_mem_ce, 0);
        chk("ar ac",   bus.o_ac, 0);
        chk("ar pc",   bus.o_pc, 0);
        chk("ar busy", bus.o_busy, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ar mem", mem[12'h080], 16'hDEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
